// File: rtl/mult_pkg.sv
// Shared multiplier definitions: FSM state encoding and default operand width.
// Also used by the divider bench when it rebuilds dividends from quotient/remainder.
package mult_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier_if.sv
// Start/done request bus of the multiply-accumulate unit: operands in, result and status out.
// The master drives the operands and start; the slave (the multiplier) drives everything else.
interface multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   x;
    logic               ovf;

    modport master (
        output start, a, y, b,
        input  busy, done, p, x, ovf
    );

    modport slave (
        input  start, a, y, b,
        output busy, done, p, x, ovf
    );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add multiply-accumulate, p = a*y + b, one multiplier bit per clock.
// Define MULTIPLIER_EARLY_EXIT_EN to finish as soon as no set multiplier bits remain.
module multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] p_reg;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last_iter;

    // A new request is taken only when no operation is in flight.
    assign accept  = ((state == IDLE) || (state == DONE)) && bus.start;
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MULTIPLIER_EARLY_EXIT_EN
    assign last_iter = (count == CW'(1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (count == CW'(1));
`endif

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            p_reg  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc    <= {{WIDTH{1'b0}}, bus.b};
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.y;
                count  <= CW'(WIDTH);
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
                if (last_iter) p_reg <= acc_sum;
            end
        end
    end

    // Result stays on p/x/ovf until the next operation overwrites it.
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.p    = p_reg;
    assign bus.x    = p_reg[WIDTH-1:0];
    assign bus.ovf  = |p_reg[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed, random, back-to-back and reset-abort scenarios
// against an arithmetic reference model of p = a*y + b and its latency.
module tb_multiplier;
    import mult_pkg::*;

    localparam int W       = WIDTH_DEFAULT;
    localparam int TIMEOUT = 4 * W;
`ifdef MULTIPLIER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    multiplier_if #(.WIDTH(W)) bus ();
    multiplier #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_p(logic [W-1:0] a, logic [W-1:0] y, logic [W-1:0] b);
        longint unsigned r;
        r = longint'(a) * longint'(y) + longint'(b);
        return (2*W)'(r);
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int model_lat(logic [W-1:0] y);
        int bits = 0;
        for (int i = 0; i < W; i++) if (y[i]) bits = i + 1;
        return EARLY ? (1 + ((bits > 1) ? bits : 1)) : (W + 1);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one request and wait for done; operands are scrambled after the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] y, input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] p_o, output logic [W-1:0] x_o,
                         output logic ovf_o, output bit busy_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.y = y;
        bus.b = b;
        lat = -1;
        busy_ok = 1'b1;
        p_o = '0;
        x_o = '0;
        ovf_o = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = W'($urandom);
            bus.y = W'($urandom);
            bus.b = W'($urandom);
            if (bus.done === 1'b1) begin
                lat = k;
                p_o = bus.p;
                x_o = bus.x;
                ovf_o = bus.ovf;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.y = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.p !== '0 || bus.x !== '0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_result: p=%h x=%h ovf=%b, required all 0", bus.p, bus.x, bus.ovf);
        end
        reset = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] y,
                            input logic [W-1:0] b);
        int lat;
        logic [2*W-1:0] p_o, exp_p;
        logic [W-1:0] x_o;
        logic ovf_o;
        bit busy_ok;
        exp_p = model_p(a, y, b);
        do_op(a, y, b, lat, p_o, x_o, ovf_o, busy_ok);
        vectors++;
        if (lat != model_lat(y)) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, model_lat(y));
        end
        vectors++;
        if (p_o !== exp_p || x_o !== exp_p[W-1:0] || ovf_o !== (|exp_p[2*W-1:W])) begin
            miscompares++;
            $display("FAIL %s_result: p=%h x=%h ovf=%b, required p=%h x=%h ovf=%b", name, p_o, x_o,
                     ovf_o, exp_p, exp_p[W-1:0], |exp_p[2*W-1:W]);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL %s_busy: busy not high for the whole run, required high until done", name);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.p !== exp_p) begin
            miscompares++;
            $display("FAIL %s_hold: done=%b busy=%b p=%h, required 0 0 %h", name, bus.done,
                     bus.busy, bus.p, exp_p);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [8] = '{16'd7, 16'hFFFF, 16'd142, 16'd9, 16'd0, 16'h1234, 16'd1, 16'h8000};
        logic [W-1:0] ty [8] = '{16'd6, 16'hFFFF, 16'd7, 16'd3, 16'hABCD, 16'd0, 16'd1, 16'h8000};
        logic [W-1:0] tb [8] = '{16'd5, 16'hFFFF, 16'd6, 16'd0, 16'hFFFF, 16'h0055, 16'd0, 16'hFFFF};
        for (int i = 0; i < 8; i++) check_op($sformatf("directed%0d", i), ta[i], ty[i], tb[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            check_op($sformatf("random%0d", i), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // start held high with fresh operands every cycle; each accept uses that cycle's operands.
    task automatic test_back_to_back();
        logic [2*W-1:0] exp_q[$];
        int done_at[$];
        int next_acc = 1;
        int seen = 0;
        bit exp_done;
        logic [W-1:0] ca, cy, cb;
        @(negedge clk);
        ca = W'($urandom);
        cy = W'($urandom);
        cb = W'($urandom);
        bus.start = 1'b1;
        bus.a = ca;
        bus.y = cy;
        bus.b = cb;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            if (k == next_acc) begin
                exp_q.push_back(model_p(ca, cy, cb));
                done_at.push_back(k + model_lat(cy) - 1);
                next_acc = k + model_lat(cy);
            end
            @(negedge clk);
            exp_done = (done_at.size() > 0) && (done_at[0] == k);
            vectors++;
            if (bus.done !== exp_done || bus.busy !== !exp_done) begin
                miscompares++;
                $display("FAIL b2b_status cycle %0d: done=%b busy=%b, required %b %b", k, bus.done,
                         bus.busy, exp_done, !exp_done);
            end
            if (exp_done) begin
                vectors++;
                if (bus.p !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_result cycle %0d: p=%h, required %h", k, bus.p, exp_q[0]);
                end
                void'(exp_q.pop_front());
                void'(done_at.pop_front());
                seen++;
            end
            ca = W'($urandom);
            cy = W'($urandom);
            cb = W'($urandom);
            bus.a = ca;
            bus.y = cy;
            bus.b = cb;
        end
        bus.start = 1'b0;
        vectors++;
        if (seen < 3) begin
            miscompares++;
            $display("FAIL b2b_count: %0d results, required at least 3", seen);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_run();
        bit saw_done = 1'b0;
        check_op("pre_abort", 16'd7, 16'd6, 16'd5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h1234;
        bus.y = 16'h8001;
        bus.b = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p !== '0 || bus.x !== '0 ||
            bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: busy=%b done=%b p=%h x=%h ovf=%b, required all 0",
                     bus.busy, bus.done, bus.p, bus.x, bus.ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL abort_no_done: done seen after abort, required none");
        end
        check_op("post_abort", 16'd3, 16'd5, 16'd2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
